axi_rresp_arbiter_4x1: RTL and testbench
========================================

Name: axi_rresp_arbiter_4x1

Overview:
- Read-data return path of the AXI interconnect: merges the R channels of 4 slaves (M00..M03) into the single master R channel.
- Locks onto one slave for a whole burst (until RLAST is handshaked), so beats from different slaves never interleave.
- Picks the next slave by round-robin.
- Drives RREADY back only to the granted slave, the master-to-slave direction of the RREADY routing.

Parameters:
- DATA_WIDTH, 32, RDATA width per slave/master.
- ID_WIDTH, 4, RID width per slave/master.

Ports:
- ACLK  input  1  clock, all state on rising edge
- ARESET  input  1  asynchronous, active-high reset
- S_RVALID  input  4  RVALID of slave i at bit i
- S_RDATA  input  4*DATA_WIDTH  slave i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- S_RRESP  input  8  slave i at [2i+:2]
- S_RLAST  input  4  RLAST of slave i at bit i
- S_RID  input  4*ID_WIDTH  slave i at [i*ID_WIDTH +: ID_WIDTH]
- S_RREADY  output  4  RREADY to slave i at bit i
- M_RVALID  output  1  to master
- M_RDATA  output  DATA_WIDTH  to master
- M_RRESP  output  2  to master
- M_RLAST  output  1  to master
- M_RID  output  ID_WIDTH  to master
- M_RREADY  input  1  from master
- GRANT_SEL  output  2  currently granted slave index
- BUSY  output  1  1 while in LOCKED state
- BEAT_CNT  output  8  beats transferred in current burst, saturates at 255

Behaviour:
- Registered state: `state` (IDLE, LOCKED), `grant[1:0]`, `last_grant[1:0]`, `beat_cnt[7:0]`.
- Reset (async, ARESET=1): state=IDLE, grant=0, last_grant=3, beat_cnt=0. All outputs go to 0 immediately, not at the next edge.
- IDLE:
  - M_RVALID=0, M_RDATA/M_RRESP/M_RLAST/M_RID=0, S_RREADY=4'b0000, BUSY=0, GRANT_SEL=grant.
  - If any S_RVALID bit is 1, on the clock edge: grant = first requesting index scanning last_grant+1, +2, +3, +4 (mod 4); state=LOCKED.
  - Arbitration costs exactly 1 cycle: the first beat can be accepted no earlier than the cycle after S_RVALID is seen in IDLE.
- LOCKED (all paths combinational from grant, no added latency):
  - M_RVALID=S_RVALID[grant]; M_RDATA, M_RRESP, M_RLAST, M_RID = selected slave's fields.
  - S_RREADY[grant]=M_RREADY; all other S_RREADY bits=0. BUSY=1.
  - Handshake = M_RVALID & M_RREADY; beat_cnt increments on each handshake, holding at 255.
  - Handshake with M_RLAST=1: next state IDLE, last_grant=grant, beat_cnt=0.
  - Requests from non-granted slaves are ignored until the burst ends. Their S_RREADY stays 0 and they must hold their data.
  - Granted slave deasserting RVALID mid-burst (protocol violation or wait state): stay LOCKED, M_RVALID=0, no beat counted.
  - Single-beat burst (RLAST on first beat): one handshake, then IDLE.
- Back-to-back bursts: one IDLE bubble cycle between a final beat and the next grant. This bubble is mandatory and is what gives round-robin fairness.
- Simultaneous requests in IDLE: resolved strictly by the round-robin order above. With last_grant=3 after reset, slave 0 has top priority.
- Reset asserted mid-burst: burst abandoned, state IDLE, last_grant=3. Upstream recovery is the responsibility of the slaves/master reset.
- No data buffering: the block is a locked multiplexer plus arbitration FSM. Backpressure from M_RREADY passes through with zero cycles.

Test Plan:
- Reset, then S_RVALID=4'b0001 with a 4-beat burst from slave 0, M_RREADY=1 -> grant 0 one cycle after request; 4 beats pass unchanged with matching RID/RRESP; BEAT_CNT goes 1,2,3 then 0; IDLE after RLAST; S_RREADY[3:1] stay 0.
- S_RVALID=4'b1111 held, each slave doing 2-beat bursts -> grant order 0,1,2,3,0, with exactly one IDLE cycle between bursts.
- Slave 2 locked and mid-burst while slave 1 raises RVALID -> slave 1's data never reaches M_RDATA and S_RREADY[1]=0 until slave 2's RLAST handshake; then slave 3 (if requesting) wins before slave 1.
- M_RREADY toggling 1,0,1,0 during a 3-beat burst -> M_R* outputs stable while stalled; only 3 handshakes counted; RLAST transferred once.
- ARESET pulsed mid-burst (beat 2 of 4) -> all outputs 0 in the same cycle; after release the next request from slave 0 wins over simultaneous slave 2.
- 300-beat burst from slave 1 -> BEAT_CNT saturates at 255 and clears to 0 after the RLAST handshake.

Source files
------------

// File: rtl/axi_rresp_arbiter_4x1.sv
// Read-data return path: merges four slave R channels onto one master R channel.
// Locks onto one slave per burst (until the RLAST handshake) and re-arbitrates round-robin.
module axi_rresp_arbiter_4x1 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [3:0]              S_RVALID,
  input  logic [4*DATA_WIDTH-1:0] S_RDATA,
  input  logic [7:0]              S_RRESP,
  input  logic [3:0]              S_RLAST,
  input  logic [4*ID_WIDTH-1:0]   S_RID,
  output logic [3:0]              S_RREADY,
  output logic                    M_RVALID,
  output logic [DATA_WIDTH-1:0]   M_RDATA,
  output logic [1:0]              M_RRESP,
  output logic                    M_RLAST,
  output logic [ID_WIDTH-1:0]     M_RID,
  input  logic                    M_RREADY,
  output logic [1:0]              GRANT_SEL,
  output logic                    BUSY,
  output logic [7:0]              BEAT_CNT
);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic [1:0]  rr_pick;
  logic [1:0]  rr_idx;
  logic        locked;
  logic        handshake;

  assign locked    = (state_q == StLocked);
  assign handshake = locked & S_RVALID[grant_q] & M_RREADY;

  // Scan offsets 4 down to 1 so the smallest offset after last_grant wins.
  always_comb begin
    rr_pick = last_grant_q;
    rr_idx  = '0;
    for (int i = 4; i >= 1; i--) begin
      rr_idx = last_grant_q + i[1:0];
      if (S_RVALID[rr_idx]) begin
        rr_pick = rr_idx;
      end
    end
  end

  always_comb begin
    M_RVALID = 1'b0;
    M_RDATA  = '0;
    M_RRESP  = '0;
    M_RLAST  = 1'b0;
    M_RID    = '0;
    S_RREADY = 4'b0000;
    if (locked) begin
      M_RVALID          = S_RVALID[grant_q];
      M_RDATA           = S_RDATA[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
      M_RRESP           = S_RRESP[32'(grant_q) * 2 +: 2];
      M_RLAST           = S_RLAST[grant_q];
      M_RID             = S_RID[32'(grant_q) * ID_WIDTH +: ID_WIDTH];
      S_RREADY[grant_q] = M_RREADY;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      StIdle: begin
        if (|S_RVALID) begin
          grant_d = rr_pick;
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (handshake) begin
          if (beat_cnt_q != 8'hFF) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
          if (S_RLAST[grant_q]) begin
            state_d      = StIdle;
            last_grant_d = grant_q;
            beat_cnt_d   = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q      <= StIdle;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd3;
      beat_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign GRANT_SEL = grant_q;
  assign BUSY      = locked;
  assign BEAT_CNT  = beat_cnt_q;

endmodule

// File: tb/tb_axi_rresp_arbiter_4x1.sv
// Directed bench for axi_rresp_arbiter_4x1: burst locking, round-robin order, stalls,
// mid-burst reset and beat-count saturation.
module tb_axi_rresp_arbiter_4x1;

  localparam int DW = 32;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    s_rvalid;
  logic [3:0]    s_rlast;
  logic [3:0]    s_rready;
  logic [DW-1:0] sd [4];
  logic [1:0]    sr [4];
  logic [IW-1:0] si [4];
  logic [4*DW-1:0] s_rdata;
  logic [7:0]      s_rresp;
  logic [4*IW-1:0] s_rid;
  logic          m_rvalid, m_rlast, m_rready, busy;
  logic [DW-1:0] m_rdata;
  logic [1:0]    m_rresp, grant_sel;
  logic [IW-1:0] m_rid;
  logic [7:0]    beat_cnt;
  logic [54:0]   obs;

  int n_tests = 0;
  int n_fail  = 0;
  int bc [4];

  always #5 clk = ~clk;

  assign s_rdata = {sd[3], sd[2], sd[1], sd[0]};
  assign s_rresp = {sr[3], sr[2], sr[1], sr[0]};
  assign s_rid   = {si[3], si[2], si[1], si[0]};
  assign obs = {m_rvalid, m_rlast, m_rresp, m_rid, m_rdata, s_rready, busy, grant_sel, beat_cnt};

  axi_rresp_arbiter_4x1 #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .ACLK      (clk),
    .ARESET    (rst),
    .S_RVALID  (s_rvalid),
    .S_RDATA   (s_rdata),
    .S_RRESP   (s_rresp),
    .S_RLAST   (s_rlast),
    .S_RID     (s_rid),
    .S_RREADY  (s_rready),
    .M_RVALID  (m_rvalid),
    .M_RDATA   (m_rdata),
    .M_RRESP   (m_rresp),
    .M_RLAST   (m_rlast),
    .M_RID     (m_rid),
    .M_RREADY  (m_rready),
    .GRANT_SEL (grant_sel),
    .BUSY      (busy),
    .BEAT_CNT  (beat_cnt)
  );

  function automatic logic [31:0] dat(input int s, input int k);
    return 32'hD000_0000 + 32'(s) * 32'h0001_0000 + 32'(k);
  endfunction

  function automatic logic [1:0] rsp(input int s, input int k);
    return 2'(s + k);
  endfunction

  function automatic logic [3:0] rid(input int s, input int k);
    return 4'(4 * s + k);
  endfunction

  function automatic logic [54:0] pack(input logic v, input logic l, input logic [1:0] rs,
                                       input logic [3:0] id, input logic [31:0] d,
                                       input logic [3:0] rdy, input logic b,
                                       input logic [1:0] gs, input logic [7:0] cnt);
    return {v, l, rs, id, d, rdy, b, gs, cnt};
  endfunction

  function automatic logic [54:0] beat_exp(input int s, input int k, input logic l,
                                           input logic [3:0] rdy, input int cnt);
    return pack(1'b1, l, rsp(s, k), rid(s, k), dat(s, k), rdy, 1'b1, 2'(s), 8'(cnt));
  endfunction

  function automatic logic [54:0] idle_exp(input int gs);
    return pack(1'b0, 1'b0, 2'b0, 4'b0, 32'b0, 4'b0, 1'b0, 2'(gs), 8'd0);
  endfunction

  task automatic set_beat(input int s, input int k, input logic last);
    sd[s]      = dat(s, k);
    sr[s]      = rsp(s, k);
    si[s]      = rid(s, k);
    s_rlast[s] = last;
  endtask

  task automatic clear_inputs();
    s_rvalid = '0;
    s_rlast  = '0;
    m_rready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sd[s] = '0;
      sr[s] = '0;
      si[s] = '0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if (obs !== idle_exp(0)) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want %h", obs, idle_exp(0));
    end
    s_rvalid = 4'hF;
    m_rready = 1'b1;
    for (int s = 0; s < 4; s++) set_beat(s, 0, 1'b1);
    @(posedge clk);
    #1;
    n_tests++;
    if (obs !== idle_exp(0)) begin
      n_fail++;
      $display("FAIL reset_held_with_req got %h want %h", obs, idle_exp(0));
    end
    clear_inputs();
  endtask

  task automatic test_single_burst();
    apply_reset();
    s_rvalid = 4'b0001;
    m_rready = 1'b1;
    set_beat(0, 0, 1'b0);
    #1;
    n_tests++;
    if (obs !== idle_exp(0)) begin
      n_fail++;
      $display("FAIL single_arb_cycle got %h want %h", obs, idle_exp(0));
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      set_beat(0, k, k == 3);
      #1;
      n_tests++;
      if (obs !== beat_exp(0, k, k == 3, 4'b0001, k)) begin
        n_fail++;
        $display("FAIL single_beat k=%0d got %h want %h", k, obs,
                 beat_exp(0, k, k == 3, 4'b0001, k));
      end
    end
    @(posedge clk);
    @(negedge clk);
    s_rvalid = 4'b0000;
    #1;
    n_tests++;
    if (obs !== idle_exp(0)) begin
      n_fail++;
      $display("FAIL single_end_idle got %h want %h", obs, idle_exp(0));
    end
  endtask

  task automatic fill_rr();
    for (int s = 0; s < 4; s++) set_beat(s, bc[s], bc[s] == 1);
  endtask

  task automatic test_round_robin();
    int g;
    int gs_prev;
    apply_reset();
    for (int s = 0; s < 4; s++) bc[s] = 0;
    fill_rr();
    s_rvalid = 4'b1111;
    m_rready = 1'b1;
    gs_prev  = 0;
    for (int b = 0; b < 5; b++) begin
      g = b % 4;
      #1;
      n_tests++;
      if (obs !== idle_exp(gs_prev)) begin
        n_fail++;
        $display("FAIL rr_bubble b=%0d got %h want %h", b, obs, idle_exp(gs_prev));
      end
      @(posedge clk);
      for (int j = 0; j < 2; j++) begin
        @(negedge clk);
        fill_rr();
        #1;
        n_tests++;
        if (obs !== beat_exp(g, j, j == 1, 4'(1 << g), j)) begin
          n_fail++;
          $display("FAIL rr_beat b=%0d j=%0d got %h want %h", b, j, obs,
                   beat_exp(g, j, j == 1, 4'(1 << g), j));
        end
        @(posedge clk);
        bc[g] = (bc[g] + 1) % 2;
      end
      @(negedge clk);
      fill_rr();
      gs_prev = g;
    end
    clear_inputs();
  endtask

  task automatic test_lock_hold();
    apply_reset();
    s_rvalid = 4'b0100;
    m_rready = 1'b1;
    set_beat(2, 0, 1'b0);
    #1;
    n_tests++;
    if (obs !== idle_exp(0)) begin
      n_fail++;
      $display("FAIL lock_arb_cycle got %h want %h", obs, idle_exp(0));
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      set_beat(2, k, k == 2);
      if (k >= 1) begin
        s_rvalid[1] = 1'b1;
        set_beat(1, 7, 1'b1);
      end
      if (k == 2) begin
        s_rvalid[3] = 1'b1;
        set_beat(3, 0, 1'b1);
      end
      #1;
      n_tests++;
      if (obs !== beat_exp(2, k, k == 2, 4'b0100, k)) begin
        n_fail++;
        $display("FAIL lock_slave2 k=%0d got %h want %h", k, obs,
                 beat_exp(2, k, k == 2, 4'b0100, k));
      end
    end
    @(posedge clk);
    @(negedge clk);
    s_rvalid[2] = 1'b0;
    #1;
    n_tests++;
    if (obs !== idle_exp(2)) begin
      n_fail++;
      $display("FAIL lock_bubble got %h want %h", obs, idle_exp(2));
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (obs !== beat_exp(3, 0, 1'b1, 4'b1000, 0)) begin
      n_fail++;
      $display("FAIL lock_next_slave3 got %h want %h", obs, beat_exp(3, 0, 1'b1, 4'b1000, 0));
    end
    @(posedge clk);
    @(negedge clk);
    s_rvalid[3] = 1'b0;
    #1;
    n_tests++;
    if (obs !== idle_exp(3)) begin
      n_fail++;
      $display("FAIL lock_bubble2 got %h want %h", obs, idle_exp(3));
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (obs !== beat_exp(1, 7, 1'b1, 4'b0010, 0)) begin
      n_fail++;
      $display("FAIL lock_then_slave1 got %h want %h", obs, beat_exp(1, 7, 1'b1, 4'b0010, 0));
    end
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_stall();
    int kb;
    int cnt;
    int n_hs;
    int n_last;
    kb     = 0;
    cnt    = 0;
    n_hs   = 0;
    n_last = 0;
    s_rvalid = 4'b0001;
    m_rready = 1'b1;
    set_beat(0, 0, 1'b0);
    #1;
    n_tests++;
    if (obs !== idle_exp(1)) begin
      n_fail++;
      $display("FAIL stall_arb_cycle got %h want %h", obs, idle_exp(1));
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      m_rready = (c % 2 == 0);
      set_beat(0, kb, kb == 2);
      #1;
      n_tests++;
      if (obs !== beat_exp(0, kb, kb == 2, m_rready ? 4'b0001 : 4'b0000, cnt)) begin
        n_fail++;
        $display("FAIL stall_cycle c=%0d got %h want %h", c, obs,
                 beat_exp(0, kb, kb == 2, m_rready ? 4'b0001 : 4'b0000, cnt));
      end
      if (m_rvalid && m_rready) n_hs++;
      if (m_rvalid && m_rready && m_rlast) n_last++;
      if (c % 2 == 0) begin
        kb++;
        cnt++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    s_rvalid = 4'b0000;
    #1;
    n_tests++;
    if (obs !== idle_exp(0)) begin
      n_fail++;
      $display("FAIL stall_end_idle got %h want %h", obs, idle_exp(0));
    end
    n_tests++;
    if (n_hs !== 3 || n_last !== 1) begin
      n_fail++;
      $display("FAIL stall_handshakes got hs=%0d last=%0d want hs=3 last=1", n_hs, n_last);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    s_rvalid = 4'b0001;
    m_rready = 1'b1;
    set_beat(0, 0, 1'b0);
    #1;
    n_tests++;
    if (obs !== idle_exp(0)) begin
      n_fail++;
      $display("FAIL rmid_arb_cycle got %h want %h", obs, idle_exp(0));
    end
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      set_beat(0, k, 1'b0);
      #1;
      n_tests++;
      if (obs !== beat_exp(0, k, 1'b0, 4'b0001, k)) begin
        n_fail++;
        $display("FAIL rmid_beat k=%0d got %h want %h", k, obs, beat_exp(0, k, 1'b0, 4'b0001, k));
      end
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (obs !== idle_exp(0)) begin
      n_fail++;
      $display("FAIL rmid_async_clear got %h want %h", obs, idle_exp(0));
    end
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    s_rvalid = 4'b0101;
    set_beat(0, 0, 1'b1);
    set_beat(2, 0, 1'b1);
    #1;
    n_tests++;
    if (obs !== idle_exp(0)) begin
      n_fail++;
      $display("FAIL rmid_after_release got %h want %h", obs, idle_exp(0));
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (obs !== beat_exp(0, 0, 1'b1, 4'b0001, 0)) begin
      n_fail++;
      $display("FAIL rmid_slave0_wins got %h want %h", obs, beat_exp(0, 0, 1'b1, 4'b0001, 0));
    end
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
    #1;
    n_tests++;
    if (obs !== idle_exp(0)) begin
      n_fail++;
      $display("FAIL rmid_single_beat_idle got %h want %h", obs, idle_exp(0));
    end
  endtask

  task automatic test_saturation();
    s_rvalid = 4'b0010;
    m_rready = 1'b1;
    set_beat(1, 0, 1'b0);
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      @(negedge clk);
      set_beat(1, k, k == 299);
      #1;
      if (k == 0 || k == 1 || k == 254 || k == 255 || k == 256 || k == 299) begin
        n_tests++;
        if (obs !== beat_exp(1, k, k == 299, 4'b0010, (k > 255) ? 255 : k)) begin
          n_fail++;
          $display("FAIL sat_beat k=%0d got %h want %h", k, obs,
                   beat_exp(1, k, k == 299, 4'b0010, (k > 255) ? 255 : k));
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    s_rvalid = 4'b0000;
    #1;
    n_tests++;
    if (obs !== idle_exp(1)) begin
      n_fail++;
      $display("FAIL sat_clear got %h want %h", obs, idle_exp(1));
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_burst();
    test_round_robin();
    test_lock_hold();
    test_stall();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
